// File: rtl/md6_pad_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md6_pad_responder_if
// DB9 pad-side bundle between a host (select driver) and the pad responder.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface md6_pad_responder_if;
  logic        six_en;
  logic [11:0] btn;
  logic        pad_sel;
  logic [5:0]  pad_d;
  logic [2:0]  phase_dbg;

  modport master (
    output six_en,
    output btn,
    output pad_sel,
    input  pad_d,
    input  phase_dbg
  );

  modport slave (
    input  six_en,
    input  btn,
    input  pad_sel,
    output pad_d,
    output phase_dbg
  );
endinterface
`default_nettype wire

// File: rtl/md6_pad_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md6_pad_responder
// Device-side Mega Drive 3/6-button pad emulation: select-driven, active-low data mux.
// Revision: 1.0
// ----------------------------------------------------------------------------
module md6_pad_responder #(
  parameter int TIMEOUT_CYC = 72000
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  md6_pad_responder_if.slave pad
);

  localparam int c_TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0] c_F_MAX6 = 3'd4;
  localparam logic [2:0] c_F_MAX3 = 3'd2;

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [2:0]         r_f;
  logic [c_TMR_W-1:0] r_tmr;
  logic [5:0]         r_pad_d;

  logic               w_fall;
  logic               w_any;
  logic               w_expired;
  logic [2:0]         w_f_max;
  logic [2:0]         w_f_next;
  logic [c_TMR_W-1:0] w_tmr_next;
  logic               w_ph3;
  logic               w_ph4;
  logic [5:0]         w_pad_d;

  // Edges are taken on the values s2/s3 are about to load, so f moves on the
  // same clock as s2 and the output register never sees old phase with new level.
  assign w_fall    = r_s2 & ~r_s1;
  assign w_any     = r_s2 ^ r_s1;
  assign w_expired = (r_tmr == c_TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= pad.pad_sel;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    w_f_max  = pad.six_en ? c_F_MAX6 : c_F_MAX3;
    w_f_next = r_f;
    if (w_any) begin
      if (w_fall && (r_f < w_f_max)) begin
        w_f_next = r_f + 3'd1;
      end
    end else if (w_expired) begin
      w_f_next = 3'd0;
    end
    // Dropping six_en mid-sequence pulls the phase back into 3-button range.
    if (w_f_next > w_f_max) begin
      w_f_next = w_f_max;
    end
  end

  always_comb begin
    w_tmr_next = r_tmr;
    if (w_any) begin
      w_tmr_next = '0;
    end else if (!w_expired) begin
      w_tmr_next = r_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f   <= 3'd0;
      r_tmr <= '0;
    end else begin
      r_f   <= w_f_next;
      r_tmr <= w_tmr_next;
    end
  end

  assign w_ph3 = pad.six_en && (r_f == 3'd3);
  assign w_ph4 = pad.six_en && (r_f == 3'd4);

  // Pin order {D5,D4,D3,D2,D1,D0}; a pressed button drives its pin low.
  always_comb begin
    w_pad_d = 6'h3F;
    if (r_s2) begin
      if (w_ph3) begin
        w_pad_d = {2'b11, ~pad.btn[11], ~pad.btn[7], ~pad.btn[8], ~pad.btn[9]};
      end else begin
        w_pad_d = {~pad.btn[6], ~pad.btn[5], ~pad.btn[0], ~pad.btn[1],
                   ~pad.btn[2], ~pad.btn[3]};
      end
    end else begin
      if (w_ph3) begin
        w_pad_d = {~pad.btn[10], ~pad.btn[4], 4'b0000};
      end else if (w_ph4) begin
        w_pad_d = {~pad.btn[10], ~pad.btn[4], 4'b1111};
      end else begin
        w_pad_d = {~pad.btn[10], ~pad.btn[4], 2'b00, ~pad.btn[2], ~pad.btn[3]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_d <= 6'h3F;
    end else begin
      r_pad_d <= w_pad_d;
    end
  end

  assign pad.pad_d     = r_pad_d;
  assign pad.phase_dbg = r_f;

  // s3 is the edge-history flop; its edge information is consumed one clock
  // early through the look-ahead above, so its value has no other sink.
  logic w_s3_unused;
  assign w_s3_unused = r_s3;

endmodule
`default_nettype wire

// File: tb/tb_md6_pad_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_md6_pad_responder
// Scoreboard bench: expected pad pins queued on each select drive, popped 3 clocks later.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_md6_pad_responder;

  localparam int c_TIMEOUT = 16;
  localparam int c_HOLD    = 3;

  typedef struct packed {
    logic [5:0] pad;
    logic [2:0] ph;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  md6_pad_responder_if bus ();

  md6_pad_responder #(.TIMEOUT_CYC(c_TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pad     (bus.slave)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   m_f;
  logic m_sel;
  logic [5:0] m_pad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin levels a real 6-button pad would present for a given phase and level.
  function automatic logic [5:0] pad_model(input int f, input logic lvl, input logic six,
                                           input logic [11:0] b);
    logic [5:0] low;
    low = 6'b0;
    if (lvl) begin
      if (six && f == 3) begin
        low[0] = b[9]; low[1] = b[8]; low[2] = b[7]; low[3] = b[11];
      end else begin
        low[0] = b[3]; low[1] = b[2]; low[2] = b[1]; low[3] = b[0];
        low[4] = b[5]; low[5] = b[6];
      end
    end else begin
      low[4] = b[4];
      low[5] = b[10];
      if (six && f == 4) begin
        low[3:0] = 4'b0000;
      end else if (six && f == 3) begin
        low[3:0] = 4'b1111;
      end else begin
        low[0] = b[3]; low[1] = b[2]; low[2] = 1'b1; low[3] = 1'b1;
      end
    end
    return ~low;
  endfunction

  task automatic do_reset(input logic six, input logic [11:0] b);
    @(negedge clk);
    reset_n     = 1'b0;
    bus.pad_sel = 1'b1;
    bus.six_en  = six;
    bus.btn     = b;
    #1;
    check_eq("rst_pad", 32'(bus.pad_d), 32'h3F);
    check_eq("rst_phase", 32'(bus.phase_dbg), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    m_f   = 0;
    m_sel = 1'b1;
    m_pad = pad_model(0, 1'b1, six, b);
    #1;
    check_eq("post_rst_pad", 32'(bus.pad_d), 32'(m_pad));
  endtask

  task automatic sel_step(input logic lvl);
    logic [5:0] prev;
    exp_t e;
    int fmax;
    @(negedge clk);
    prev = m_pad;
    fmax = bus.six_en ? 4 : 2;
    if (m_sel && !lvl && m_f < fmax) m_f = m_f + 1;
    m_sel       = lvl;
    bus.pad_sel = lvl;
    m_pad       = pad_model(m_f, lvl, bus.six_en, bus.btn);
    q.push_back('{pad: m_pad, ph: 3'(m_f)});
    repeat (2) @(posedge clk);
    #1;
    check_eq("pad_early", 32'(bus.pad_d), 32'(prev));
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check_eq("pad_d", 32'(bus.pad_d), 32'(e.pad));
      check_eq("phase", 32'(bus.phase_dbg), 32'(e.ph));
    end
    repeat (c_HOLD) @(posedge clk);
  endtask

  initial begin
    bus.pad_sel = 1'b1;
    bus.six_en  = 1'b1;
    bus.btn     = 12'h000;

    // Idle pad, then one select low: D2/D3 forced low.
    do_reset(1'b1, 12'h000);
    sel_step(1'b0);

    // Full 6-button cycle with U+A+Start.
    do_reset(1'b1, 12'h418);
    for (int i = 0; i < 8; i++) sel_step((i % 2) == 0);

    // Six-en drop while in post phase clamps f to 2 on the next clock.
    @(negedge clk);
    bus.six_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("clamp_phase", 32'(bus.phase_dbg), 32'd2);
    check_eq("clamp_pad", 32'(bus.pad_d), 32'(pad_model(4, 1'b0, 1'b0, 12'h418)));
    m_f   = 2;
    m_pad = pad_model(2, 1'b0, 1'b0, 12'h418);

    // Extended phase with X+Z+Mode, then async reset in that phase.
    do_reset(1'b1, 12'hA80);
    for (int i = 0; i < 6; i++) sel_step((i % 2) == 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_pad", 32'(bus.pad_d), 32'h3F);
    check_eq("async_rst_phase", 32'(bus.phase_dbg), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    m_f   = 0;
    m_sel = 1'b1;
    m_pad = pad_model(0, 1'b1, 1'b1, 12'hA80);
    sel_step(1'b0);

    // 3-button mode never shows ID/extended phases.
    do_reset(1'b0, 12'hA80);
    for (int i = 0; i < 8; i++) sel_step((i % 2) == 1);

    // Button change reaches the pins on the next clock.
    @(negedge clk);
    bus.btn = 12'h021;
    m_pad   = pad_model(m_f, m_sel, 1'b0, 12'h021);
    @(posedge clk);
    #1;
    check_eq("btn_latency", 32'(bus.pad_d), 32'(m_pad));

    // Falling edge landing on the expiry clock: edge wins.
    @(negedge clk);
    reset_n     = 1'b0;
    bus.six_en  = 1'b1;
    bus.btn     = 12'h000;
    bus.pad_sel = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    bus.pad_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("edge_on_expiry", 32'(bus.phase_dbg), 32'd1);
    check_eq("edge_on_expiry_pad", 32'(bus.pad_d), 32'(pad_model(1, 1'b0, 1'b1, 12'h000)));

    // Idle boundary: 15 clocks after the edge still live, expired on the 16th.
    repeat (14) @(posedge clk);
    #1;
    check_eq("idle_before_expiry", 32'(bus.phase_dbg), 32'd1);
    @(posedge clk);
    #1;
    check_eq("idle_expired", 32'(bus.phase_dbg), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_held", 32'(bus.phase_dbg), 32'd0);
    m_f   = 0;
    m_sel = 1'b0;
    m_pad = pad_model(0, 1'b0, 1'b1, 12'h000);
    sel_step(1'b1);
    sel_step(1'b0);

    if (q.size() != 0) check_eq("queue_leftover", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
